// File: rtl/fifo_wr_stream_adapter.sv
// Two-entry skid buffer between a valid/ready producer and an async-FIFO
// write port, with saturating write and stall statistics.
module fifo_wr_stream_adapter #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  output logic             in_ready,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  input  logic             wfull,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [DSIZE-1:0] slot0, slot1, slot0_nxt, slot1_nxt;
  logic             push, pop, stall;

  // Ready comes from registered state only, so upstream sees no comb path
  // from wfull. Reset forces EMPTY asynchronously, which drops winc and
  // raises in_ready without waiting for a clock.
  assign in_ready = (state != TWO);
  assign winc     = (state != EMPTY) && !wfull;
  // slot0 is left untouched when the buffer drains, so wdata holds its
  // last value while EMPTY.
  assign wdata    = slot0;
  assign push     = in_valid && in_ready;
  assign pop      = winc;
  assign stall    = (state != EMPTY) && wfull;

  // Occupancy and slot registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state <= EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      state <= state_nxt;
      slot0 <= slot0_nxt;
      slot1 <= slot1_nxt;
    end
  end

  // Next occupancy and slot contents; new words always land behind
  // whatever survives this edge.
  always_comb begin
    state_nxt = state;
    slot0_nxt = slot0;
    slot1_nxt = slot1;
    case (state)
      EMPTY: begin
        if (push) begin
          slot0_nxt = in_data;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          slot0_nxt = in_data;
        end else if (push) begin
          slot1_nxt = in_data;
          state_nxt = TWO;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          slot0_nxt = slot1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wr_count    <= '0;
      stall_count <= '0;
    end else if (clr_stats) begin
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (pop && (wr_count != CNT_MAX))
        wr_count <= wr_count + CNT_ONE;
      if (stall && (stall_count != CNT_MAX))
        stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fifo_wr_stream_adapter.sv
// Randomized + directed bench: a queue-based reference model records every
// accepted word; a negedge monitor pops and checks each FIFO write.
module tb_fifo_wr_stream_adapter;

  logic        wclk = 1'b0;
  logic        wrst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        wfull = 1'b0;
  logic        clr_stats = 1'b0;
  logic        in_ready, winc;
  logic [7:0]  wdata;
  logic [15:0] wr_count, stall_count;
  logic        s_in_ready, s_winc;
  logic [7:0]  s_wdata;
  logic [3:0]  s_wr_count, s_stall_count;

  int total = 0;
  int bad = 0;

  // Reference model: words accepted but not yet written, plus raw counts.
  logic [7:0] exp_q[$];
  int occ = 0;
  int m_wr = 0;
  int m_st = 0;
  bit m_push = 1'b0;
  bit m_pu, m_pp;

  fifo_wr_stream_adapter #(.DSIZE(8), .CNT_W(16)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .winc(winc), .wdata(wdata), .wfull(wfull),
    .clr_stats(clr_stats), .wr_count(wr_count), .stall_count(stall_count)
  );

  fifo_wr_stream_adapter #(.DSIZE(8), .CNT_W(4)) dut_small (
    .wclk(wclk), .wrst_n(wrst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .winc(s_winc), .wdata(s_wdata), .wfull(wfull),
    .clr_stats(clr_stats), .wr_count(s_wr_count), .stall_count(s_stall_count)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Model update: a word is accepted while fewer than two are held; the
  // oldest is written whenever one is held and the FIFO is not full.
  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      occ = 0; m_wr = 0; m_st = 0; m_push = 1'b0;
      exp_q.delete();
    end else begin
      m_pp = (occ > 0) && !wfull;
      m_pu = in_valid && (occ < 2);
      if (clr_stats) begin
        m_wr = 0; m_st = 0;
      end else begin
        if (m_pp) m_wr++;
        if ((occ > 0) && wfull) m_st++;
      end
      if (m_pu) exp_q.push_back(in_data);
      occ = occ + int'(m_pu) - int'(m_pp);
      m_push = m_pu;
    end
  end

  // Monitor: checks handshake, counters and every written word.
  always @(negedge wclk) begin
    logic [7:0] want;
    chk("in_ready", in_ready, occ < 2);
    chk("winc", winc, (occ > 0) && !wfull);
    chk("s_winc", s_winc, (occ > 0) && !wfull);
    if (winc) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wdata: unexpected write of %0h with nothing pending at %0t", wdata, $time);
      end else begin
        want = exp_q.pop_front();
        chk("wdata", wdata, want);
        chk("s_wdata", s_wdata, want);
      end
    end
    chk("wr_count", wr_count, sat(m_wr, 65535));
    chk("stall_count", stall_count, sat(m_st, 65535));
    chk("s_wr_count", s_wr_count, sat(m_wr, 15));
    chk("s_stall_count", s_stall_count, sat(m_st, 15));
  end

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  // Offer a word and hold it until the model says it was accepted.
  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (m_push) return;
    end
    total++; bad++;
    $display("FAIL send_timeout: word %0h not accepted, expected within 200 cycles", d);
  endtask

  initial begin
    // Reset values while wrst_n is still low.
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_winc", winc, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_stall_count", stall_count, 0);
    wrst_n = 1'b1;
    cyc();

    // Single word, one cycle latency.
    send(8'hA5);
    in_valid = 1'b0;
    chk("a5_winc", winc, 1);
    chk("a5_wdata", wdata, 8'hA5);
    cyc();
    chk("a5_wr_count", wr_count, 1);

    // Full FIFO: two words buffer, third is held upstream.
    wfull = 1'b1;
    send(8'h11);
    send(8'h22);
    in_data = 8'h33;
    for (int i = 0; i < 3; i++) begin
      chk("full_in_ready", in_ready, 0);
      chk("full_winc", winc, 0);
      cyc();
    end
    wfull = 1'b0;
    send(8'h33);
    in_valid = 1'b0;
    repeat (4) cyc();

    // Sixteen back-to-back words.
    clr_stats = 1'b1;
    cyc();
    clr_stats = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(i));
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("stream_wr_count", wr_count, 16);

    // Reset mid-cycle while holding two words.
    wfull = 1'b1;
    send(8'h44);
    send(8'h55);
    in_valid = 1'b0;
    chk("two_in_ready", in_ready, 0);
    #2;
    wrst_n = 1'b0;
    wfull = 1'b0;
    #1;
    chk("midrst_winc", winc, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_wr_count", wr_count, 0);
    #2;
    wrst_n = 1'b1;
    repeat (4) cyc();

    // Saturation of the narrow counter, then clear racing a write.
    clr_stats = 1'b1;
    cyc();
    clr_stats = 1'b0;
    for (int i = 0; i < 20; i++) send(8'($urandom));
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("sat_s_wr_count", s_wr_count, 15);
    chk("sat_wr_count", wr_count, 20);
    send(8'h77);
    in_valid = 1'b0;
    chk("clr_winc", winc, 1);
    clr_stats = 1'b1;
    cyc();
    clr_stats = 1'b0;
    chk("clr_wr_count", wr_count, 0);
    chk("clr_s_wr_count", s_wr_count, 0);
    repeat (2) cyc();

    // Random traffic with backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      wfull = ($urandom % 10) < 3;
      clr_stats = ($urandom % 50) == 0;
      if (!in_valid || m_push) begin
        in_valid = ($urandom % 4) != 0;
        in_data = 8'($urandom);
      end
      cyc();
    end
    in_valid = 1'b0;
    wfull = 1'b0;
    clr_stats = 1'b0;
    repeat (5) cyc();
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_stream_adapter.md
FIFO_WR_STREAM_ADAPTER -- requirements
Module: fifo_wr_stream_adapter

Interface
REQ-001 SHALL have parameter DSIZE, default 8, meaning data word width (matches FIFO write data width).
REQ-002 SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-003 SHALL have port wclk, input, 1, write-domain clock; all state on its rising edge.
REQ-004 SHALL have port wrst_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1, upstream word valid.
REQ-006 SHALL have port in_data, input, DSIZE, upstream word.
REQ-007 SHALL have port in_ready, output, 1, adapter can accept a word this cycle.
REQ-008 SHALL have port winc, output, 1, FIFO write enable.
REQ-009 SHALL have port wdata, output, DSIZE, FIFO write data.
REQ-010 SHALL have port wfull, input, 1, FIFO full flag (write domain).
REQ-011 SHALL have port clr_stats, input, 1, synchronous clear of both counters.
REQ-012 SHALL have port wr_count, output, CNT_W, number of words written to the FIFO.
REQ-013 SHALL have port stall_count, output, CNT_W, number of cycles a word was blocked by wfull.

Function
REQ-014 SHALL hold a 2-entry in-order buffer (slot0 = head) with occupancy state EMPTY (0), ONE (1), TWO (2).
REQ-015 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO; in_ready depends only on registered state.
REQ-016 SHALL accept a word (push) on a rising edge where in_valid && in_ready; in_data is captured into the first free slot.
REQ-017 SHALL drive winc = (state != EMPTY) && !wfull, combinationally from wfull.
REQ-018 SHALL drive wdata = slot0 whenever state != EMPTY; wdata holds last value when EMPTY.
REQ-019 SHALL treat a rising edge with winc = 1 as a pop: slot1 shifts to slot0.
REQ-020 SHALL transition on push only: EMPTY->ONE, ONE->TWO; on pop only: TWO->ONE, ONE->EMPTY; push and pop together: state unchanged, new word enters behind the remaining entry (in ONE: into slot0 after the old head leaves).
REQ-021 SHALL give 1-cycle latency: a word pushed at edge N, with buffer previously EMPTY, appears on wdata with winc = 1 in the cycle after edge N if wfull = 0.
REQ-022 SHALL never drop, duplicate or reorder words; an ignored in_valid (in_ready = 0) requires upstream to hold in_data.
REQ-023 SHALL keep winc = 0 while wfull = 1 regardless of occupancy; the head word and its wdata value are held stable until written.
REQ-024 SHALL increment wr_count by 1 on every edge with winc = 1, saturating at all-ones (no wrap).
REQ-025 SHALL increment stall_count by 1 on every edge with state != EMPTY && wfull = 1, saturating at all-ones.
REQ-026 SHALL give clr_stats priority over increments: both counters read 0 after that edge.
REQ-027 SHALL, at state TWO with wfull = 0, sustain one write per cycle with in_ready re-asserting the next cycle (throughput 1 word/cycle when upstream and FIFO both stream).

Reset
REQ-028 SHALL, on wrst_n = 0, asynchronously set state EMPTY, slot0/slot1/wdata = 0, wr_count = 0, stall_count = 0.
REQ-029 SHALL force winc = 0 and in_ready = 1 during reset, independent of wclk.
REQ-030 SHALL discard buffered words when reset asserts mid-operation; no write of them occurs after release.
REQ-031 SHALL resume normal operation on the first rising edge after wrst_n deasserts.

Verification
REQ-032 SHALL cover: reset, then in_valid = 1 with in_data = 0xA5 for one cycle, wfull = 0 -> next cycle winc = 1, wdata = 0xA5; wr_count = 1.
REQ-033 SHALL cover: wfull = 1, push 0x11, 0x22, 0x33 back-to-back -> in_ready = 0 after two pushes, 0x33 held by upstream, winc = 0, stall_count increments each cycle; drop wfull -> 0x11, 0x22, 0x33 written in order on consecutive cycles.
REQ-034 SHALL cover: continuous in_valid with 0x00..0x0F and wfull = 0 -> 16 consecutive winc cycles, data in order, wr_count = 16.
REQ-035 SHALL cover: state TWO holding 0x44, 0x55, wrst_n pulsed low mid-cycle -> winc = 0, in_ready = 1 immediately; neither 0x44 nor 0x55 is ever written.
REQ-036 SHALL cover: with CNT_W = 4, 20 writes -> wr_count = 15 (saturated); clr_stats = 1 simultaneous with a write -> wr_count = 0 next cycle.
